// File: rtl/br_result_update_queue_pkg.sv
// Shared fetch-unit types: the queued branch-result record and the PHT index
// that is derived from a branch address.
package FetchUnitTypes;

  localparam int ADDR_W = 32;
  localparam int IDX_W = 10;
  localparam int PREV_W = 16;
  localparam int BR_UPDATE_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              taken;
    logic              mispred;
    logic              cond;
    logic [PREV_W-1:0] prev;
  } BrResultEntry;

  // Word-aligned branch address bits select the PHT counter.
  function automatic logic [IDX_W-1:0] phtIndex(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W+1:2];
  endfunction

endpackage

// File: rtl/br_result_update_queue_select.sv
// Picks how many queued results leave this cycle. Delivery stops at the first
// PHT index collision or right after a mispredicted conditional branch.
module br_update_select
  import FetchUnitTypes::*;
#(
  parameter int WIDTH = 2
) (
  input  BrResultEntry     slotEntry [WIDTH],
  input  logic [WIDTH-1:0] slotPresent,
  output logic [WIDTH-1:0] slotValid,
  output logic             conflict
);

  logic hit;

  // NOTE: every output is given a default before the loop so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    slotValid    = '0;
    conflict     = 1'b0;
    hit          = 1'b0;
    slotValid[0] = slotPresent[0];
    for (int k = 1; k < WIDTH; k++) begin
      hit = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (phtIndex(slotEntry[j].addr) == phtIndex(slotEntry[k].addr)) hit = 1'b1;
      end
      // A mispredicted conditional closes the window before any index compare,
      // so it is never counted as a conflict.
      if (slotPresent[k] && slotValid[k-1] &&
          !(slotEntry[k-1].mispred && slotEntry[k-1].cond)) begin
        if (hit) conflict = 1'b1;
        else     slotValid[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/br_result_update_queue.sv
// Queue of resolved branch results feeding the predictor update ports, in order,
// with no two same-cycle deliveries sharing a PHT index.
module br_result_update_queue
  import FetchUnitTypes::*;
#(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = BR_UPDATE_QUEUE_DEPTH,
  parameter int STAT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_valid,
  input  logic [WIDTH*ADDR_W-1:0]  in_addr,
  input  logic [WIDTH-1:0]         in_taken,
  input  logic [WIDTH-1:0]         in_mispred,
  input  logic [WIDTH-1:0]         in_cond,
  input  logic [WIDTH*PREV_W-1:0]  in_prev,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_valid,
  output logic [WIDTH*ADDR_W-1:0]  out_addr,
  output logic [WIDTH-1:0]         out_taken,
  output logic [WIDTH-1:0]         out_mispred,
  output logic [WIDTH-1:0]         out_cond,
  output logic [WIDTH*PREV_W-1:0]  out_prev,
  output logic                     out_any_mispred,
  output logic [STAT_W-1:0]        conflict_stalls
);

  localparam int LANE_W = $clog2(DEPTH);
  localparam int PTR_W  = LANE_W + 1;

  BrResultEntry     mem [DEPTH];
  BrResultEntry     laneEntry [WIDTH];
  BrResultEntry     slotEntry [WIDTH];
  logic [PTR_W-1:0] head, tail, count, pushCnt, popCnt;
  logic [PTR_W-1:0] wrOffset [WIDTH];
  logic [LANE_W-1:0] wrAddr [WIDTH];
  logic [LANE_W-1:0] rdAddr [WIDTH];
  logic [WIDTH-1:0] slotPresent, selValid;
  logic             conflict;

  // The wrap bit makes tail - head the occupancy even when the lanes alias.
  assign count    = tail - head;
  assign in_ready = (PTR_W'(DEPTH) - count) >= PTR_W'(WIDTH);

  always_comb begin
    pushCnt = '0;
    popCnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wrOffset[i]  = pushCnt;
      wrAddr[i]    = LANE_W'(tail + pushCnt);
      pushCnt      = pushCnt + PTR_W'(in_valid[i]);
      laneEntry[i] = '{addr:    in_addr[i*ADDR_W +: ADDR_W],
                       taken:   in_taken[i],
                       mispred: in_mispred[i],
                       cond:    in_cond[i],
                       prev:    in_prev[i*PREV_W +: PREV_W]};
      rdAddr[i]      = LANE_W'(head + PTR_W'(i));
      slotEntry[i]   = mem[rdAddr[i]];
      slotPresent[i] = count > PTR_W'(i);
      popCnt         = popCnt + PTR_W'(selValid[i]);
    end
  end

  br_update_select #(.WIDTH(WIDTH)) u_select (
    .slotEntry  (slotEntry),
    .slotPresent(slotPresent),
    .slotValid  (selValid),
    .conflict   (conflict)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      conflict_stalls <= '0;
    end else begin
      head <= head + popCnt;
      if (in_ready) tail <= tail + pushCnt;
      if (conflict && !(&conflict_stalls)) conflict_stalls <= conflict_stalls + STAT_W'(1);
    end
  end

  // NOTE: the storage array has no reset; occupancy comes from the pointers,
  // so stale contents are never delivered.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!rst && in_ready && in_valid[i]) mem[wrAddr[i]] <= laneEntry[i];
    end
  end

  always_comb begin
    out_valid   = selValid;
    out_addr    = '0;
    out_taken   = '0;
    out_mispred = '0;
    out_cond    = '0;
    out_prev    = '0;
    for (int k = 0; k < WIDTH; k++) begin
      out_addr[k*ADDR_W +: ADDR_W] = slotEntry[k].addr;
      out_taken[k]                 = slotEntry[k].taken;
      out_mispred[k]               = slotEntry[k].mispred;
      out_cond[k]                  = slotEntry[k].cond;
      out_prev[k*PREV_W +: PREV_W] = slotEntry[k].prev;
    end
    out_any_mispred = |(selValid & out_mispred);
  end

  // Producers must hold off while the queue cannot take a full lane group.
  noPushWhenFull: assert property (@(posedge clk) disable iff (rst)
    !((|in_valid) && !in_ready));

endmodule

// File: tb/tb_br_result_update_queue.sv
// Self-checking bench: a queue-based reference model predicts every output each
// cycle; directed scenarios add literal expectations that pin the model.
module tb_br_result_update_queue;
  import FetchUnitTypes::*;

  localparam int WIDTH  = 2;
  localparam int DEPTH  = 8;
  localparam int STAT_W = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [WIDTH-1:0]        in_valid, in_taken, in_mispred, in_cond;
  logic [WIDTH*ADDR_W-1:0] in_addr;
  logic [WIDTH*PREV_W-1:0] in_prev;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_valid, out_taken, out_mispred, out_cond;
  logic [WIDTH*ADDR_W-1:0] out_addr;
  logic [WIDTH*PREV_W-1:0] out_prev;
  logic                    out_any_mispred;
  logic [STAT_W-1:0]       conflict_stalls;

  always #5 clk = ~clk;

  br_result_update_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_addr(in_addr), .in_taken(in_taken),
    .in_mispred(in_mispred), .in_cond(in_cond), .in_prev(in_prev),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_addr(out_addr), .out_taken(out_taken),
    .out_mispred(out_mispred), .out_cond(out_cond), .out_prev(out_prev),
    .out_any_mispred(out_any_mispred), .conflict_stalls(conflict_stalls)
  );

  BrResultEntry     model [$];
  int               stallModel;
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] expValid;
  logic             expConflict;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idxOf(input logic [ADDR_W-1:0] a);
    return int'((a >> 2) % (1 << IDX_W));
  endfunction

  // Walk the head of the model queue applying the delivery rules.
  task automatic predict();
    expValid    = '0;
    expConflict = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (k >= model.size()) break;
      if (k > 0 && model[k-1].mispred && model[k-1].cond) break;
      begin
        bit dup = 0;
        for (int j = 0; j < k; j++) if (idxOf(model[j].addr) == idxOf(model[k].addr)) dup = 1;
        if (dup) begin
          expConflict = 1'b1;
          break;
        end
      end
      expValid[k] = 1'b1;
    end
  endtask

  task automatic compareOutputs();
    bit anyMis = 0;
    predict();
    check("out_valid", out_valid, expValid);
    for (int k = 0; k < WIDTH; k++) begin
      if (expValid[k]) begin
        check("out_addr",    out_addr[k*ADDR_W +: ADDR_W], model[k].addr);
        check("out_taken",   out_taken[k],   model[k].taken);
        check("out_mispred", out_mispred[k], model[k].mispred);
        check("out_cond",    out_cond[k],    model[k].cond);
        check("out_prev",    out_prev[k*PREV_W +: PREV_W], model[k].prev);
        if (model[k].mispred) anyMis = 1;
      end
    end
    check("out_any_mispred", out_any_mispred, anyMis);
    check("in_ready", in_ready, (DEPTH - model.size()) >= WIDTH);
    check("conflict_stalls", conflict_stalls, stallModel);
  endtask

  task automatic clearInputs();
    in_valid = '0; in_taken = '0; in_mispred = '0; in_cond = '0;
    in_addr = '0; in_prev = '0;
  endtask

  task automatic setLane(input int i, input logic [ADDR_W-1:0] a, input logic t,
                         input logic m, input logic c, input logic [PREV_W-1:0] p);
    in_valid[i]   = 1'b1;
    in_addr[i*ADDR_W +: ADDR_W] = a;
    in_taken[i]   = t;
    in_mispred[i] = m;
    in_cond[i]    = c;
    in_prev[i*PREV_W +: PREV_W] = p;
  endtask

  // One clock: update the model with what the edge commits, then check the
  // following cycle's outputs and release the inputs.
  task automatic tick();
    bit ready;
    @(posedge clk);
    ready = (DEPTH - model.size()) >= WIDTH;
    if (rst) begin
      model.delete();
      stallModel = 0;
    end else begin
      for (int k = 0; k < WIDTH; k++) if (expValid[k]) void'(model.pop_front());
      if (expConflict && stallModel < STAT_MAX) stallModel++;
      if (ready) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (in_valid[i]) model.push_back('{addr: in_addr[i*ADDR_W +: ADDR_W],
              taken: in_taken[i], mispred: in_mispred[i], cond: in_cond[i],
              prev: in_prev[i*PREV_W +: PREV_W]});
        end
      end
    end
    @(negedge clk);
    compareOutputs();
    clearInputs();
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    stallModel = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    compareOutputs();
    check("reset_out_valid", out_valid, 2'b00);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_stalls", conflict_stalls, 0);

    // Two distinct indices leave together, lane order kept.
    setLane(0, 32'h100, 1'b1, 1'b0, 1'b1, 16'h1111);
    setLane(1, 32'h204, 1'b0, 1'b0, 1'b1, 16'h2222);
    tick();
    check("pair_valid", out_valid, 2'b11);
    check("pair_addr", out_addr, {32'h204, 32'h100});
    tick();
    check("pair_drained", out_valid, 2'b00);

    // Same PHT index: one per cycle, one conflict counted.
    setLane(0, 32'h100, 1'b1, 1'b0, 1'b1, 16'h0001);
    setLane(1, 32'h1100, 1'b1, 1'b0, 1'b1, 16'h0002);
    tick();
    check("conf_first", out_valid, 2'b01);
    tick();
    check("conf_second", out_valid, 2'b01);
    check("conf_second_addr", out_addr[31:0], 32'h1100);
    check("conf_stalls", conflict_stalls, 1);
    tick();

    // Mispredicted conditional ends its delivery group.
    setLane(0, 32'h100, 1'b1, 1'b1, 1'b1, 16'h0003);
    setLane(1, 32'h204, 1'b0, 1'b0, 1'b1, 16'h0004);
    tick();
    check("mis_first", out_valid, 2'b01);
    check("mis_any", out_any_mispred, 1'b1);
    tick();
    check("mis_second", out_valid, 2'b01);
    check("mis_second_addr", out_addr[31:0], 32'h204);
    check("mis_conf_none", conflict_stalls, 1);
    tick();

    // Fill with one shared index so draining is one per cycle; pointers wrap.
    for (int n = 0; n < 6; n++) begin
      setLane(0, 32'h100 | (32'(2*n)   << 12), 1'b0, 1'b0, 1'b1, 16'(n));
      setLane(1, 32'h100 | (32'(2*n+1) << 12), 1'b1, 1'b0, 1'b1, 16'(n));
      tick();
    end
    check("fill_not_ready", in_ready, 1'b0);
    repeat (8) tick();
    check("fill_empty", out_valid, 2'b00);

    // Reset with five entries queued; inputs during reset are ignored.
    for (int n = 0; n < 4; n++) begin
      setLane(0, 32'h300 | (32'(2*n)   << 12), 1'b0, 1'b0, 1'b0, 16'h0);
      setLane(1, 32'h300 | (32'(2*n+1) << 12), 1'b0, 1'b0, 1'b0, 16'h0);
      tick();
    end
    rst = 1'b1;
    setLane(0, 32'h500, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    setLane(1, 32'h604, 1'b1, 1'b1, 1'b1, 16'hFFFF);
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 2'b00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_stalls", conflict_stalls, 0);

    // Random traffic over a small index pool to provoke conflicts and wraps.
    for (int c = 0; c < 2000; c++) begin
      if (in_ready) begin
        for (int i = 0; i < WIDTH; i++) begin
          if ($urandom_range(0, 3) != 0) begin
            setLane(i, ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 3)) << 2) | ($urandom & 32'h3),
                    1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom));
          end
        end
      end
      tick();
    end
    check("stall_saturated", conflict_stalls, STAT_MAX);
    repeat (DEPTH + 2) tick();
    check("final_empty", out_valid, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
